// File: rtl/coin_start_seq.sv
// Keyboard/joystick merger that drives the cabinet inputs, with an optional coin-then-start sequencer.
// Sequencer is built only when SEQ_AUTOCOIN_EN is defined; otherwise coin and start follow the start buttons directly.
module coin_start_seq #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [64:0] PS2_KEY,
  input  logic [15:0] JOY,
  input  logic        VBLANK,
  output logic [7:0]  IN0,
  output logic [7:0]  IN1,
  output logic        BUSY
);

  // key_q bits 0..6 line up with JOY bits 0..6; bit 7 is the second fire key.
  logic [7:0] key_q, key_d;
  logic       toggle_q, vblank_q;
  logic       ps2_evt_s, press_s, vb_edge_s;
  logic [6:0] ctrl_s;
  logic       coin_s, st1_s, st2_s;
  logic       unused_s;

  assign unused_s  = ^{PS2_KEY[23:16], JOY[15:7]};
  assign ps2_evt_s = (PS2_KEY[64] != toggle_q) && (PS2_KEY[63:24] == 40'd0);
  assign press_s   = (PS2_KEY[15:8] != 8'hF0);
  assign vb_edge_s = VBLANK && !vblank_q;

  // Key latch next-state from the scan code of a fresh event.
  always_comb begin
    key_d = key_q;
    if (ps2_evt_s) begin
      case (PS2_KEY[7:0])
        8'h74:   key_d[0] = press_s;
        8'h6B:   key_d[1] = press_s;
        8'h72:   key_d[2] = press_s;
        8'h75:   key_d[3] = press_s;
        8'h29:   key_d[4] = press_s;
        8'h05:   key_d[5] = press_s;
        8'h06:   key_d[6] = press_s;
        8'h14:   key_d[7] = press_s;
        default: key_d = key_q;
      endcase
    end else begin
      key_d = key_q;
    end
  end

  // Input-side registers: key latches, PS2 toggle history, VBLANK history.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_q    <= 8'd0;
      toggle_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      toggle_q <= PS2_KEY[64];
      vblank_q <= VBLANK;
    end
  end

  // Gating with RESET_N keeps the outputs at their reset pattern even with joystick bits high.
  assign ctrl_s = ({key_q[6:5], key_q[4] | key_q[7], key_q[3:0]} | JOY[6:0]) & {7{RESET_N}};

`ifdef SEQ_AUTOCOIN_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COIN    = 3'd1,
    S_GAP     = 3'd2,
    S_START   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc_s;
  logic       entry_q, entry_d;
  logic       sel_q, sel_d;
  logic       count_s;

  function automatic logic frames_done(input logic [7:0] cnt, input logic [31:0] n);
    return ({24'd0, cnt} + 32'd1) >= n;
  endfunction

  assign cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign count_s   = vb_edge_s && !entry_q;

  // Sequencer next-state; every transition clears the counter and flags the entry cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = 1'b0;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_s[5] || ctrl_s[6]) begin
          state_d = S_COIN;
          sel_d   = !ctrl_s[5];
          cnt_d   = 8'd0;
          entry_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COIN: begin
        if (count_s && frames_done(cnt_q, 32'(COIN_FRAMES))) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
          entry_d = 1'b1;
        end else if (count_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_GAP: begin
        if (count_s && frames_done(cnt_q, 32'(GAP_FRAMES))) begin
          state_d = S_START;
          cnt_d   = 8'd0;
          entry_d = 1'b1;
        end else if (count_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_START: begin
        if (count_s && frames_done(cnt_q, 32'(START_FRAMES))) begin
          state_d = S_RELEASE;
          cnt_d   = 8'd0;
          entry_d = 1'b1;
        end else if (count_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RELEASE: begin
        if (!ctrl_s[5] && !ctrl_s[6]) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          entry_d = 1'b1;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      entry_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      sel_q   <= sel_d;
    end
  end

  assign coin_s = (state_q == S_COIN);
  assign st1_s  = (state_q == S_START) && !sel_q;
  assign st2_s  = (state_q == S_START) && sel_q;
  assign BUSY   = (state_q != S_IDLE);
`else
  assign coin_s = ctrl_s[5] | ctrl_s[6];
  assign st1_s  = ctrl_s[5];
  assign st2_s  = ctrl_s[6];
  assign BUSY   = 1'b0;
`endif

  assign IN0 = {2'b11, ~coin_s, ctrl_s[4], ctrl_s[2], ctrl_s[0], ctrl_s[1], ctrl_s[3]};
  assign IN1 = {1'b0, st2_s, st1_s, ctrl_s[4], ctrl_s[2], ctrl_s[0], ctrl_s[1], ctrl_s[3]};

endmodule

// File: tb/tb_coin_start_seq.sv
// Self-checking bench for coin_start_seq: per-cycle reference model plus directed literal checks.
module tb_coin_start_seq;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [64:0] PS2_KEY;
  logic [15:0] JOY;
  logic        VBLANK;
  wire  [7:0]  IN0;
  wire  [7:0]  IN1;
  wire         BUSY;

  int checks = 0;
  int errors = 0;

  localparam int C = 4;
  localparam int G = 8;
  localparam int S = 4;

  always #5 CLK = ~CLK;

  coin_start_seq #(.COIN_FRAMES(C), .GAP_FRAMES(G), .START_FRAMES(S)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PS2_KEY(PS2_KEY), .JOY(JOY),
    .VBLANK(VBLANK), .IN0(IN0), .IN1(IN1), .BUSY(BUSY)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, {7'd0, got}, {7'd0, exp});
  endtask

  // Reference model: set of pressed scan codes, and a sequence described by
  // the number of counted VBLANK edges since a start was accepted.
  bit   pressed [256];
  logic ps2_prev, vb_prev;
  bit   active, sel2;
  int   edges, age;

  initial begin
    logic up, dn, lf, rt, fi, s1, s2, coin, st1, st2, busy_e;
    logic [7:0] e0, e1;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        foreach (pressed[i]) pressed[i] = 1'b0;
        ps2_prev = 1'b0; vb_prev = 1'b0;
        active = 1'b0; sel2 = 1'b0; edges = 0; age = 0;
        e0 = 8'hE0; e1 = 8'h00; busy_e = 1'b0;
      end else begin
        rt = pressed[8'h74] | JOY[0];
        lf = pressed[8'h6B] | JOY[1];
        dn = pressed[8'h72] | JOY[2];
        up = pressed[8'h75] | JOY[3];
        fi = pressed[8'h29] | pressed[8'h14] | JOY[4];
        s1 = pressed[8'h05] | JOY[5];
        s2 = pressed[8'h06] | JOY[6];
`ifdef SEQ_AUTOCOIN_EN
        coin   = active && (edges < C);
        st1    = active && (edges >= C + G) && (edges < C + G + S) && !sel2;
        st2    = active && (edges >= C + G) && (edges < C + G + S) && sel2;
        busy_e = active;
`else
        coin   = s1 | s2;
        st1    = s1;
        st2    = s2;
        busy_e = 1'b0;
`endif
        e0 = {2'b11, ~coin, fi, dn, rt, lf, up};
        e1 = {1'b0, st2, st1, fi, dn, rt, lf, up};
        // advance the model by the coming rising edge
        if (active) begin
          if ((edges >= C + G + S) && !s1 && !s2) active = 1'b0;
          else begin
            if (age >= 1 && VBLANK && !vb_prev) edges++;
            age++;
          end
        end else if (s1 || s2) begin
          active = 1'b1; sel2 = !s1; edges = 0; age = 0;
        end
        if (PS2_KEY[64] !== ps2_prev && PS2_KEY[63:24] == 40'd0)
          pressed[PS2_KEY[7:0]] = (PS2_KEY[15:8] != 8'hF0);
        ps2_prev = PS2_KEY[64];
        vb_prev  = VBLANK;
      end
      chk("model_in0", IN0, e0);
      chk("model_in1", IN1, e1);
      chk1("model_busy", BUSY, busy_e);
    end
  end

  logic tog = 1'b0;

  task automatic ps2(input logic [39:0] hi, input logic [7:0] pfx, input logic [7:0] code);
    tog = ~tog;
    PS2_KEY = {tog, hi, 8'h00, pfx, code};
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      VBLANK = 1'b1;
      cyc(1);
      VBLANK = 1'b0;
      cyc(99);
    end
  endtask

  initial begin
    RESET_N = 1'b0; JOY = 16'h0000; PS2_KEY = 65'd0; VBLANK = 1'b0;
    #2;
    chk("reset_in0", IN0, 8'hE0);
    chk("reset_in1", IN1, 8'h00);
    chk1("reset_busy", BUSY, 1'b0);
    cyc(3);
    RESET_N = 1'b1;
    cyc(2);

    // Filtered vs accepted up-arrow event
    ps2(40'h0000000001, 8'h00, 8'h75);
    cyc(2);
    chk1("ps2_masked_up", IN0[0], 1'b0);
    ps2(40'd0, 8'h00, 8'h75);
    chk1("ps2_up_before_edge", IN0[0], 1'b0);
    cyc(1);
    chk1("ps2_up_after_edge", IN0[0], 1'b1);
    ps2(40'd0, 8'hF0, 8'h75);
    cyc(1);
    chk1("ps2_up_released", IN0[0], 1'b0);
    cyc(3);

`ifdef SEQ_AUTOCOIN_EN
    // F1 single press drives the full sequence
    ps2(40'd0, 8'h00, 8'h05);
    cyc(2);
    chk1("f1_coin_on", IN0[5], 1'b0);
    chk1("f1_busy", BUSY, 1'b1);
    cyc(5);
    frames(3);
    chk1("f1_coin_3", IN0[5], 1'b0);
    frames(1);
    chk1("f1_coin_off", IN0[5], 1'b1);
    frames(7);
    chk1("f1_gap_7", IN1[5], 1'b0);
    frames(1);
    chk("f1_start_on", {6'd0, IN1[6:5]}, 8'h01);
    frames(3);
    chk1("f1_start_3", IN1[5], 1'b1);
    frames(1);
    chk1("f1_start_off", IN1[5], 1'b0);
    chk1("f1_release_busy", BUSY, 1'b1);
    ps2(40'd0, 8'hF0, 8'h05);
    cyc(2);
    chk1("f1_idle", BUSY, 1'b0);
    cyc(5);

    // F2 pressed during GAP does not alter or re-arm the sequence
    ps2(40'd0, 8'h00, 8'h05);
    cyc(7);
    frames(6);
    ps2(40'd0, 8'h00, 8'h06);
    cyc(2);
    chk1("f2_gap_nocoin", IN0[5], 1'b1);
    frames(6);
    chk("f2_start_sel", {6'd0, IN1[6:5]}, 8'h01);
    ps2(40'd0, 8'hF0, 8'h05);
    cyc(1);
    ps2(40'd0, 8'hF0, 8'h06);
    cyc(1);
    frames(4);
    chk1("f2_idle", BUSY, 1'b0);
    frames(2);
    chk1("f2_no_second_coin", IN0[5], 1'b1);
    chk1("f2_still_idle", BUSY, 1'b0);

    // Both joystick starts together, held through START
    JOY = 16'h0060;
    cyc(6);
    frames(12);
    chk("joy_start_prio", {6'd0, IN1[6:5]}, 8'h01);
    frames(4);
    chk1("joy_release_hold", BUSY, 1'b1);
    frames(2);
    chk1("joy_release_hold2", BUSY, 1'b1);
    JOY = 16'h0000;
    cyc(1);
    chk1("joy_idle_1cyc", BUSY, 1'b0);
    cyc(3);

    // Reset mid-COIN
    JOY = 16'h0020;
    cyc(1);
    JOY = 16'h0000;
    cyc(3);
    chk1("rst_pre_coin", IN0[5], 1'b0);
`else
    // Pass-through build: coin and start follow the buttons
    JOY = 16'h0020;
    #1;
    chk1("pt_coin", IN0[5], 1'b0);
    chk1("pt_start1", IN1[5], 1'b1);
    chk1("pt_busy", BUSY, 1'b0);
    JOY = 16'h0000;
    ps2(40'd0, 8'h00, 8'h06);
    cyc(1);
    chk1("pt_f2_start2", IN1[6], 1'b1);
    chk1("pt_f2_coin", IN0[5], 1'b0);
    ps2(40'd0, 8'hF0, 8'h06);
    cyc(1);
    chk1("pt_f2_off", IN1[6], 1'b0);
    JOY = 16'h0020;
    cyc(3);
`endif
    #3;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_in0", IN0, 8'hE0);
    chk("rst_async_in1", IN1, 8'h00);
    chk1("rst_async_busy", BUSY, 1'b0);
    JOY = 16'h0000;
    cyc(2);
    RESET_N = 1'b1;
    cyc(3);
    chk1("rst_idle_busy", BUSY, 1'b0);
    chk("rst_idle_in0", IN0, 8'hE0);
    frames(1);
    chk("rst_idle_in1", IN1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_start_seq.md
COIN_START_SEQ -- requirements
Module: coin_start_seq

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 4: number of VBLANK rising edges the coin line is held.
REQ-002 SHALL have parameter GAP_FRAMES, default 8: number of VBLANK rising edges between coin release and start assertion.
REQ-003 SHALL have parameter START_FRAMES, default 4: number of VBLANK rising edges the start line is held.
REQ-004 SHALL have port CLK, input, width 1: the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port RESET_N, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port PS2_KEY, input, width 65: keyboard event word; bit 64 toggles once per event.
REQ-007 SHALL have port JOY, input, width 16: merged joystick; bits 0–6 are right, left, down, up, fire, start1, start2.
REQ-008 SHALL have port VBLANK, input, width 1: video vertical blank, synchronous to CLK.
REQ-009 SHALL have port IN0, output, width 8: {1, 1, ~coin, fire, down, right, left, up}.
REQ-010 SHALL have port IN1, output, width 8: {0, start2, start1, fire, down, right, left, up}.
REQ-011 SHALL have port BUSY, output, width 1: high whenever the sequencer is not in IDLE.

Function
REQ-012 SHALL register a keyboard event only on the cycle after bit 64 of PS2_KEY differs from its previous registered value.
REQ-013 SHALL ignore any keyboard event whose PS2_KEY[63:24] is nonzero.
REQ-014 SHALL treat an event as a press when PS2_KEY[15:8] != 0xF0, and as a release otherwise.
REQ-015 SHALL latch key states from these scan codes (extended flag ignored for the arrow keys): 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x29 and 0x14 fire, 0x05 start1, 0x06 start2; all other codes SHALL be ignored.
REQ-016 SHALL form each control as the OR of its key latch and the corresponding JOY bit.
REQ-017 SHALL drive the direction and fire fields of IN0 and IN1 combinationally from the merged controls, with zero added latency.
REQ-018 SHALL detect a VBLANK rising edge as VBLANK=1 while its registered previous value is 0.
REQ-019 SHALL implement a sequencer FSM with states IDLE, COIN, GAP, START and RELEASE.
REQ-020 SHALL transition IDLE→COIN on the first cycle in which merged start1 or start2 is high.
REQ-021 SHALL, on the IDLE→COIN transition, latch the player selection, with start1 taking priority when start1 and start2 are pressed in the same cycle.
REQ-022 SHALL hold coin high in COIN, and SHALL transition COIN→GAP after COIN_FRAMES VBLANK edges.
REQ-023 SHALL transition GAP→START after GAP_FRAMES VBLANK edges.
REQ-024 SHALL drive only the latched start bit in START, and SHALL transition START→RELEASE after START_FRAMES VBLANK edges.
REQ-025 SHALL hold in RELEASE until merged start1 and start2 are both low, then transition to IDLE.
REQ-026 SHALL clear the frame counter on every state entry; a VBLANK edge on the entry cycle SHALL NOT be counted.
REQ-027 SHALL use an 8-bit frame counter that saturates rather than wraps.
REQ-028 SHALL ignore start presses received while BUSY is high; no request is queued.
REQ-029 SHALL NOT pass raw start inputs to IN1; start bits are driven only by the START state.

Reset
REQ-030 SHALL, while RESET_N is low, immediately force: FSM to IDLE, all key latches to 0, frame counter to 0, VBLANK-edge and PS2-toggle registers to 0, IN0 = 0xE0, IN1 = 0x00, BUSY = 0.
REQ-031 SHALL, when reset is asserted mid-sequence, release coin and start asynchronously and resume in IDLE.

Configuration
REQ-032 SHALL, when SEQ_AUTOCOIN_EN is defined, include the FSM behaviour of REQ-019 to REQ-029.
REQ-033 SHALL, when SEQ_AUTOCOIN_EN is undefined, drive coin = start1 | start2 and pass the start bits directly to IN1, hold BUSY at 0, and omit the FSM and counter.

Verification
REQ-034 SHALL verify, with the macro defined: a single F1 press event, then VBLANK pulses every 100 cycles → IN0[5]=0 for 4 edges, then 1 for 8 edges, then IN1[5]=1 for 4 edges; IN1[6] stays 0 throughout.
REQ-035 SHALL verify: JOY[5] and JOY[6] rise in the same cycle → IN1[5] asserted in START and IN1[6] never asserted.
REQ-036 SHALL verify: an F2 press during GAP → no change to the sequence, and no second coin after IDLE is reached.
REQ-037 SHALL verify: start held through START → FSM stays in RELEASE with BUSY=1 until release, then goes to IDLE within 1 cycle.
REQ-038 SHALL verify: RESET_N pulsed low in COIN → IN0=0xE0, IN1=0x00 and BUSY=0 asynchronously, with IDLE after release.
REQ-039 SHALL verify: PS2_KEY with code 0x75 and bits[63:24] nonzero → IN0[0] remains 0; the same event with bits[63:24]=0 → IN0[0]=1 one cycle after the toggle.
